scan_ctrl8: RTL and testbench
=============================

Name: scan_ctrl8

Overview:
- Time-multiplexed digit scanner for an 8-digit display.
- Generates the 3-bit select index and active-high enable that drive the 3-to-8 decoder directly downstream.
- Also outputs the 4-bit nibble for the currently selected digit.
- Inserts blanking (enable low) between digits to prevent ghosting, skips masked digits, and flags each completed frame.

Parameters:
- CLK_DIV, 4: clock cycles each digit is shown (dec_en high); legal range >= 1.
- BLANK_CYCLES, 1: dec_en-low cycles between digits; legal range >= 0. A value of 0 means back-to-back digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  scan enable; sampled every cycle.
- digit_mask  input  8  bit i = 1 means digit i is scanned.
- digits  input  32  digit i nibble = digits[4i+3:4i].
- sel  output  3  decoder data input (digit index).
- dec_en  output  1  decoder enable.
- digit_data  output  4  nibble of digit sel while dec_en = 1; 0 otherwise.
- frame_done  output  1  one-cycle pulse when the scan wraps to the lowest enabled digit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), all other logic synchronous to clk rising edge.
- All outputs are registered.
- Reset values: state IDLE, sel=0, dec_en=0, digit_data=0, frame_done=0, dwell counter=0.
- Reset asserted mid-operation clears all outputs immediately (asynchronous).
- States: IDLE, SHOW, BLANK.
- IDLE: dec_en=0, sel holds its value.
  - If run=1 and digit_mask!=0: load sel with the lowest set mask index, load the counter, go to SHOW.
  - dec_en rises on the cycle after run is first sampled high.
  - frame_done is not pulsed on entry from IDLE.
- SHOW: dec_en=1 for exactly CLK_DIV cycles; digit_data = digits[4*sel+:4], tracking live changes to digits with one-cycle latency.
  - After the last cycle, go to BLANK if BLANK_CYCLES>0; otherwise advance directly.
- BLANK: dec_en=0, digit_data=0, sel holds the old index, for exactly BLANK_CYCLES cycles; then advance.
- Advance:
  - next sel = lowest set mask bit strictly above the current sel; if none, wrap to the lowest set bit overall.
  - A wrap (new index <= old index) pulses frame_done=1 in the first SHOW cycle of the new digit.
  - With a single enabled digit, sel stays constant and frame_done pulses every CLK_DIV+BLANK_CYCLES cycles.
- Digit period: CLK_DIV+BLANK_CYCLES cycles. Full frame: popcount(mask)*(CLK_DIV+BLANK_CYCLES).
- run=0 sampled in SHOW or BLANK: go to IDLE on the next edge, dec_en=0, digit_data=0.
  - A restart always begins at the lowest enabled digit.
- digit_mask is sampled only at advance and at IDLE exit.
  - Clearing the current digit's bit mid-slot lets that slot finish.
  - If the mask is 0 at an advance, go to IDLE (no frame_done).
- run=1 with digit_mask=0 in IDLE: remain in IDLE.
- Dwell counter width: clog2(max(CLK_DIV, BLANK_CYCLES)+1); no overflow at the legal extremes.

Decomposition:
- Shared package scan_pkg:
  - state enum (IDLE, SHOW, BLANK);
  - default constants SCAN_CLK_DIV_DEF=4 and SCAN_BLANK_DEF=1;
  - NUM_DIGITS=8;
  - SEL_W=3.
- One combinational sub-module, next_digit_sel:
  - inputs: cur sel[2:0], mask[7:0];
  - outputs: next index[2:0], wrap flag, any flag.
  - It is reused for IDLE-exit with cur treated as "before 0" (via the wrap path).

Test Plan:
- Reset: hold rst_n=0 with run=1 -> all outputs 0. Pulse rst_n low mid-SHOW -> dec_en=0 and sel=0 immediately, without a clock edge.
- Full scan, defaults, mask=8'hFF, digits=32'h76543210, run rises before edge 0:
  - sel=0 with dec_en=1 in cycles 1-4, dec_en=0 in cycle 5, sel=1 in cycles 6-9, ..., sel=7 in cycles 36-39;
  - sel=0 in cycle 41 with frame_done=1 for one cycle;
  - digit_data equals sel in every SHOW cycle and is 0 during BLANK.
- Sparse mask 8'b1010_0100 -> sel sequence 2,5,7,2,...; frame_done only on return to 2; digit 2 dwell is 4 cycles.
- run deasserted in the 2nd SHOW cycle of sel=3 -> dec_en=0 next cycle, state IDLE. Reassert run -> restart at sel=0 with no frame_done.
- Mask edge cases:
  - mask=0 with run=1 -> dec_en stays 0 indefinitely;
  - mask=8'h80 -> sel=7 constant, frame_done every 5 cycles;
  - mask cleared to 0 mid-SHOW -> slot completes, then IDLE.
- Parameter variant CLK_DIV=1, BLANK_CYCLES=0, mask=8'h03 -> dec_en continuously 1, sel toggles 0,1,0,1 each cycle, frame_done on every return to 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the 8-digit display scanner.
package scan_pkg;
    localparam int unsigned NUM_DIGITS       = 8;
    localparam int unsigned SEL_W            = 3;
    localparam int unsigned NIBBLE_W         = 4;
    localparam int unsigned SCAN_CLK_DIV_DEF = 4;
    localparam int unsigned SCAN_BLANK_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;
endpackage

// File: rtl/next_digit_sel.sv
// Picks the next enabled digit above cur, wrapping to the lowest enabled digit.
module next_digit_sel
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]      cur,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [SEL_W-1:0]      nxt,
    output logic                  wrap,
    output logic                  any
);
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic             hi_found;

    // Scan downward so the last hit is the lowest qualifying bit.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = SEL_W'(i);
                if (i > int'(cur)) begin
                    hi_idx   = SEL_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign nxt  = hi_found ? hi_idx : lo_idx;
    assign wrap = ~hi_found;
    assign any  = |mask;
endmodule

// File: rtl/scan_ctrl8.sv
// Time-multiplexed 8-digit scanner: select index, decoder enable, nibble and frame pulse.
module scan_ctrl8
    import scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = SCAN_CLK_DIV_DEF,
    parameter int unsigned BLANK_CYCLES = SCAN_BLANK_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [NUM_DIGITS-1:0]          digit_mask,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    output logic [SEL_W-1:0]               sel,
    output logic                           dec_en,
    output logic [NIBBLE_W-1:0]            digit_data,
    output logic                           frame_done
);
    localparam int unsigned MAX_DWELL = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL + 1) : 1;
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               adv;
    logic [SEL_W-1:0]   sel_d;
    logic               dec_en_d;
    logic [NIBBLE_W-1:0] data_d;
    logic               frame_done_d;

    logic [SEL_W-1:0]   nds_cur;
    logic [SEL_W-1:0]   nds_nxt;
    logic               nds_wrap;
    logic               nds_any;

    // From IDLE, cur = top index forces the wrap path to yield the lowest enabled digit.
    assign nds_cur = (state_q == IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel;

    next_digit_sel u_next_digit_sel (
        .cur  (nds_cur),
        .mask (digit_mask),
        .nxt  (nds_nxt),
        .wrap (nds_wrap),
        .any  (nds_any)
    );

    // State, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel        <= '0;
            dec_en     <= 1'b0;
            digit_data <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel        <= sel_d;
            dec_en     <= dec_en_d;
            digit_data <= data_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and dwell counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && nds_any) begin
                    state_d = SHOW;
                    cnt_d   = SHOW_LOAD;
                end
            end
            SHOW: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // An empty mask at the slot boundary parks the scanner.
        if (adv) begin
            if (nds_any) begin
                state_d = SHOW;
                cnt_d   = SHOW_LOAD;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        sel_d        = sel;
        dec_en_d     = 1'b0;
        data_d       = '0;
        frame_done_d = 1'b0;
        if (state_d == SHOW) begin
            dec_en_d = 1'b1;
            if (state_q == IDLE || adv) begin
                sel_d = nds_nxt;
            end
            frame_done_d = adv & nds_wrap;
            data_d       = digits[{sel_d, 2'b00} +: NIBBLE_W];
        end
    end
endmodule

// File: tb/tb_scan_ctrl8.sv
// Scoreboard bench for scan_ctrl8: default build plus a CLK_DIV=1/BLANK_CYCLES=0 build.
module tb_scan_ctrl8;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  digit_mask;
    logic [31:0] digits;
    logic [2:0]  sel;
    logic        dec_en;
    logic [3:0]  digit_data;
    logic        frame_done;

    logic        run_f;
    logic [7:0]  mask_f;
    logic [2:0]  sel_f;
    logic        en_f;
    logic [3:0]  data_f;
    logic        fd_f;

    int total = 0;
    int bad   = 0;

    // Entries are {sel, dec_en, digit_data, frame_done}.
    logic [8:0] sb[$];
    logic [8:0] exp_v;
    logic [8:0] got_v;

    scan_ctrl8 u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .digit_mask (digit_mask),
        .digits     (digits),
        .sel        (sel),
        .dec_en     (dec_en),
        .digit_data (digit_data),
        .frame_done (frame_done)
    );

    scan_ctrl8 #(.CLK_DIV(1), .BLANK_CYCLES(0)) u_dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_f),
        .digit_mask (mask_f),
        .digits     (digits),
        .sel        (sel_f),
        .dec_en     (en_f),
        .digit_data (data_f),
        .frame_done (fd_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [31:0] d, input int i);
        return d[4*i +: 4];
    endfunction

    // Expected trace of one digit slot: show cycles then blank cycles.
    task automatic push_slot(input logic [2:0] s, input logic fd, input logic [3:0] dat,
                             input int show, input int blank);
        for (int k = 0; k < show; k++) sb.push_back({s, 1'b1, dat, (k == 0) ? fd : 1'b0});
        for (int k = 0; k < blank; k++) sb.push_back({s, 1'b0, 4'h0, 1'b0});
    endtask

    task automatic go_idle();
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; run_f = 1'b1;
        digit_mask = 8'hFF; mask_f = 8'h03; digits = 32'h76543210;
        repeat (3) @(negedge clk);
        total++;
        if ({sel, dec_en, digit_data, frame_done} !== 9'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h required=0", {sel, dec_en, digit_data, frame_done});
        end
        total++;
        if ({sel_f, en_f, data_f, fd_f} !== 9'h0) begin
            bad++;
            $display("FAIL reset_hold_fast got=%h required=0", {sel_f, en_f, data_f, fd_f});
        end
        run = 1'b0; run_f = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan();
        digit_mask = 8'hFF; digits = 32'h76543210;
        for (int d = 0; d < 8; d++) push_slot(3'(d), 1'b0, 4'(d), 4, 1);
        push_slot(3'd0, 1'b1, 4'd0, 4, 1);
        run = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel, dec_en, digit_data, frame_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL full_scan cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
        end
        go_idle();
    endtask

    task automatic test_sparse();
        logic [2:0] order[3];
        order[0] = 3'd2; order[1] = 3'd5; order[2] = 3'd7;
        digit_mask = 8'b1010_0100; digits = $urandom;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
                push_slot(order[j], (r > 0 && j == 0), nib(digits, int'(order[j])), 4, 1);
        run = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel, dec_en, digit_data, frame_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL sparse cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
        end
        go_idle();
    endtask

    // Single digit 7; digits changes mid-slot and must show one cycle later.
    task automatic test_single();
        logic [31:0] old_d, new_d;
        old_d = 32'h9000_0000; new_d = 32'h5000_0000;
        digit_mask = 8'h80; digits = old_d;
        for (int c = 1; c <= 15; c++) begin
            logic en;
            en = ((c - 1) % 5) < 4;
            sb.push_back({3'd7, en, en ? ((c >= 8) ? 4'h5 : 4'h9) : 4'h0,
                          ((c - 1) % 5 == 0) && (c > 1)});
        end
        run = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel, dec_en, digit_data, frame_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL single cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
            if (c == 7) digits = new_d;
        end
        go_idle();
    endtask

    task automatic test_run_drop();
        digit_mask = 8'hFF; digits = 32'h76543210;
        for (int d = 0; d < 3; d++) push_slot(3'(d), 1'b0, 4'(d), 4, 1);
        push_slot(3'd3, 1'b0, 4'd3, 2, 2);
        push_slot(3'd0, 1'b0, 4'd0, 4, 1);
        run = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel, dec_en, digit_data, frame_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL run_drop cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
            if (c == 17) run = 1'b0;
            if (c == 19) run = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_mask_zero();
        digit_mask = 8'h00;
        run = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            total++;
            if ({dec_en, frame_done} !== 2'b00) begin
                bad++;
                $display("FAIL mask_zero cyc=%0d got_en_fd=%b required=00", c, {dec_en, frame_done});
            end
        end
        go_idle();
    endtask

    task automatic test_mask_clear();
        digit_mask = 8'hFF; digits = 32'h76543210;
        push_slot(3'd0, 1'b0, 4'd0, 4, 1);
        push_slot(3'd1, 1'b0, 4'd1, 4, 1);
        push_slot(3'd1, 1'b0, 4'd0, 0, 4);
        run = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel, dec_en, digit_data, frame_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL mask_clear cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
            if (c == 7) digit_mask = 8'h00;
        end
        go_idle();
        digit_mask = 8'hFF;
    endtask

    task automatic test_fast();
        digits = 32'h0000_00C3; mask_f = 8'h03;
        for (int c = 1; c <= 10; c++) begin
            int s;
            s = (c - 1) % 2;
            sb.push_back({3'(s), 1'b1, nib(digits, s), (s == 0) && (c > 1)});
        end
        run_f = 1'b1;
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            got_v = {sel_f, en_f, data_f, fd_f};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL fast cyc=%0d got=%h required=%h", c, got_v, exp_v);
            end
        end
        run_f = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Reset pulsed between clock edges while sel=3 is showing.
    task automatic test_reset_async();
        digit_mask = 8'hFF; digits = 32'h76543210;
        run = 1'b1;
        repeat (17) @(negedge clk);
        total++;
        if ({sel, dec_en} !== 4'b0111) begin
            bad++;
            $display("FAIL async_pre got_sel_en=%b required=0111", {sel, dec_en});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sel, dec_en, digit_data, frame_done} !== 9'h0) begin
            bad++;
            $display("FAIL async_reset got=%h required=0", {sel, dec_en, digit_data, frame_done});
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_single();
        test_run_drop();
        test_mask_zero();
        test_mask_clear();
        test_fast();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
